// File: rtl/encrypter_scheduler.sv
// Round-robin dispatch/collect scheduler for a bank of encrypter lanes.
// Words go to lanes in strict rotation and results are drained in the same rotation, so output order equals input order.

module encrypter_scheduler_lane #(
    parameter int SEL_W = 2,
    parameter int LANE  = 0
) (
    input  logic [SEL_W-1:0] dp,
    input  logic [SEL_W-1:0] cp,
    input  logic             accept,
    input  logic             capture,
    input  logic             pgm_all,
    output logic             dispatch,
    output logic             capture_stb,
    output logic             pgm_stb
);
    localparam logic [SEL_W-1:0] ID = SEL_W'(LANE);

    assign dispatch    = accept  & (dp == ID);
    assign capture_stb = capture & (cp == ID);
    assign pgm_stb     = pgm_all;
endmodule

module encrypter_scheduler #(
    parameter int NUM_ENCRYPTERS = 4,
    parameter int SEL_W          = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      prog,
    input  logic                      word_valid,
    input  logic                      word_last,
    output logic                      word_accept,
    input  logic [NUM_ENCRYPTERS-1:0] enc_ready,
    output logic [NUM_ENCRYPTERS-1:0] enc_program,
    output logic [NUM_ENCRYPTERS-1:0] enc_dispatch,
    input  logic [NUM_ENCRYPTERS-1:0] enc_done,
    output logic                      col_valid,
    output logic [SEL_W-1:0]          col_select,
    input  logic                      col_ack,
    output logic [NUM_ENCRYPTERS-1:0] enc_capture,
    output logic                      busy,
    output logic                      msg_done
);
    typedef enum logic [2:0] {IDLE, PROG, KEYWAIT, RUN, DRAIN} state_t;

    localparam logic [SEL_W:0] FULL = (SEL_W+1)'(NUM_ENCRYPTERS);

    state_t           state;
    logic [SEL_W-1:0] dp;
    logic [SEL_W-1:0] cp;
    logic [SEL_W:0]   inflight;
    logic             active;
    logic             capture;
    logic             pgm_all;

    assign active      = (state == RUN) || (state == DRAIN);
    assign pgm_all     = (state == PROG);
    assign word_accept = (state == RUN) & word_valid & enc_ready[dp] & (inflight < FULL);
    assign col_valid   = active & (inflight != '0) & enc_done[cp];
    assign capture     = col_valid & col_ack;
    assign col_select  = cp;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dp       <= '0;
            cp       <= '0;
            inflight <= '0;
            msg_done <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            if (word_accept) dp <= dp + SEL_W'(1);
            if (capture)     cp <= cp + SEL_W'(1);
            case ({word_accept, capture})
                2'b10:   inflight <= inflight + (SEL_W+1)'(1);
                2'b01:   inflight <= inflight - (SEL_W+1)'(1);
                default: ;
            endcase
            case (state)
                IDLE:    if (prog) state <= PROG;
                PROG:    state <= KEYWAIT;
                KEYWAIT: if (&enc_ready) state <= RUN;
                RUN:     if (word_accept && word_last) state <= DRAIN;
                DRAIN: begin
                    // Pointers already coincide when empty; zeroing keeps every message starting at lane 0.
                    if (inflight == '0) begin
                        state    <= IDLE;
                        msg_done <= 1'b1;
                        dp       <= '0;
                        cp       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_ENCRYPTERS; i++) begin : g_lane
        encrypter_scheduler_lane #(.SEL_W(SEL_W), .LANE(i)) u_lane (
            .dp          (dp),
            .cp          (cp),
            .accept      (word_accept),
            .capture     (capture),
            .pgm_all     (pgm_all),
            .dispatch    (enc_dispatch[i]),
            .capture_stb (enc_capture[i]),
            .pgm_stb     (enc_program[i])
        );
    end
endmodule

// File: tb/tb_encrypter_scheduler.sv
// Bench for encrypter_scheduler: directed vector table, corner sequences, and random traffic
// checked against a queue-based model of lane order.

module tb_encrypter_scheduler;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset, prog, word_valid, word_last, col_ack;
    logic          word_accept, col_valid, busy, msg_done;
    logic [N-1:0]  enc_ready, enc_done, enc_program, enc_dispatch, enc_capture;
    logic [SW-1:0] col_select;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encrypter_scheduler #(.NUM_ENCRYPTERS(N), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset), .prog(prog), .word_valid(word_valid), .word_last(word_last),
        .word_accept(word_accept), .enc_ready(enc_ready), .enc_program(enc_program),
        .enc_dispatch(enc_dispatch), .enc_done(enc_done), .col_valid(col_valid),
        .col_select(col_select), .col_ack(col_ack), .enc_capture(enc_capture),
        .busy(busy), .msg_done(msg_done)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase of the message, queue of lanes holding unread results, next lane in rotation.
    typedef enum int {M_IDLE, M_PROG, M_KEY, M_RUN, M_DRAIN} mphase_t;
    mphase_t ph;
    int      q[$];
    int      nxt;
    bit      md;

    task automatic model_reset();
        ph = M_IDLE; q.delete(); nxt = 0; md = 1'b0;
    endtask

    // Called mid-cycle with inputs stable: compare outputs, then advance model across the next edge.
    task automatic step(input string tag);
        int           head;
        bit           acc, cv, cap, md_n;
        logic [N-1:0] e_disp, e_cap, e_pgm;
        head   = (q.size() > 0) ? q[0] : nxt;
        acc    = (ph == M_RUN) && word_valid && enc_ready[nxt] && (q.size() < N);
        cv     = (q.size() > 0) && enc_done[head];
        cap    = cv && col_ack;
        e_disp = '0; if (acc) e_disp[nxt]  = 1'b1;
        e_cap  = '0; if (cap) e_cap[head]  = 1'b1;
        e_pgm  = (ph == M_PROG) ? '1 : '0;
        chk({tag, ":accept"},   8'(word_accept),  8'(acc));
        chk({tag, ":dispatch"}, 8'(enc_dispatch), 8'(e_disp));
        chk({tag, ":capture"},  8'(enc_capture),  8'(e_cap));
        chk({tag, ":program"},  8'(enc_program),  8'(e_pgm));
        chk({tag, ":col_valid"},8'(col_valid),    8'(cv));
        chk({tag, ":col_sel"},  8'(col_select),   8'(head));
        chk({tag, ":busy"},     8'(busy),         8'(ph != M_IDLE));
        chk({tag, ":msg_done"}, 8'(msg_done),     8'(md));
        md_n = 1'b0;
        case (ph)
            M_IDLE:  if (prog) ph = M_PROG;
            M_PROG:  ph = M_KEY;
            M_KEY:   if (&enc_ready) ph = M_RUN;
            M_RUN:   if (acc && word_last) ph = M_DRAIN;
            M_DRAIN: if (q.size() == 0) begin ph = M_IDLE; md_n = 1'b1; nxt = 0; end
            default: ;
        endcase
        if (cap) void'(q.pop_front());
        if (acc) begin q.push_back(nxt); nxt = (nxt + 1) % N; end
        md = md_n;
    endtask

    task automatic drive(input logic p, wv, wl, input logic [N-1:0] rdy, dn, input logic a);
        prog = p; word_valid = wv; word_last = wl; enc_ready = rdy; enc_done = dn; col_ack = a;
    endtask

    task automatic cyc(input logic p, wv, wl, input logic [N-1:0] rdy, dn, input logic a, input string tag);
        @(posedge clk); #1;
        drive(p, wv, wl, rdy, dn, a);
        @(negedge clk);
        step(tag);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, 0);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Keep acking until msg_done, bounded.
    task automatic drain(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc(0, 0, 0, '1, '1, 1, tag);
            seen = msg_done;
        end
        chk({tag, ":msg_done_seen"}, 8'(seen), 8'd1);
    endtask

    typedef struct {
        logic p, wv, wl; logic [3:0] rdy, dn; logic ack;
        logic acc; logic [3:0] disp, cap, pgm; logic cv; logic [1:0] cs; logic bsy, md;
    } vec_t;
    vec_t tbl[13];

    initial begin
        //          p    wv   wl   rdy   dn    ack  | acc  disp  cap   pgm   cv   cs    busy md
        tbl[0]  = '{1'b1,1'b0,1'b0,4'h0,4'h0,1'b0, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,4'h0,4'h0,1'b0, 1'b0,4'h0,4'h0,4'hF,1'b0,2'd0,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,4'h7,4'h0,1'b0, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd0,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,4'hF,4'h0,1'b0, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd0,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,4'hF,4'h0,1'b0, 1'b1,4'h1,4'h0,4'h0,1'b0,2'd0,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,4'hF,4'h1,1'b1, 1'b1,4'h2,4'h1,4'h0,1'b1,2'd0,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b1,4'hF,4'h2,1'b0, 1'b1,4'h4,4'h0,4'h0,1'b1,2'd1,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b0,4'hF,4'h2,1'b1, 1'b0,4'h0,4'h2,4'h0,1'b1,2'd1,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,4'hF,4'h0,1'b1, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd2,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,4'hF,4'h4,1'b1, 1'b0,4'h0,4'h4,4'h0,1'b1,2'd2,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,4'hF,4'h0,1'b0, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd3,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,4'hF,4'h0,1'b0, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd0,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b0,1'b0,4'hF,4'h0,1'b0, 1'b0,4'h0,4'h0,4'h0,1'b0,2'd0,1'b0,1'b0};

        reset = 1'b0;
        drive(0, 1, 0, '1, '1, 1);
        #12;
        chk("rst:accept",   8'(word_accept),  8'd0);
        chk("rst:dispatch", 8'(enc_dispatch), 8'd0);
        chk("rst:capture",  8'(enc_capture),  8'd0);
        chk("rst:program",  8'(enc_program),  8'd0);
        chk("rst:col_valid",8'(col_valid),    8'd0);
        chk("rst:col_sel",  8'(col_select),   8'd0);
        chk("rst:busy",     8'(busy),         8'd0);
        chk("rst:msg_done", 8'(msg_done),     8'd0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].p, tbl[i].wv, tbl[i].wl, tbl[i].rdy, tbl[i].dn, tbl[i].ack);
            @(negedge clk);
            chk($sformatf("tbl%0d:accept", i),   8'(word_accept),  8'(tbl[i].acc));
            chk($sformatf("tbl%0d:dispatch", i), 8'(enc_dispatch), 8'(tbl[i].disp));
            chk($sformatf("tbl%0d:capture", i),  8'(enc_capture),  8'(tbl[i].cap));
            chk($sformatf("tbl%0d:program", i),  8'(enc_program),  8'(tbl[i].pgm));
            chk($sformatf("tbl%0d:col_valid", i),8'(col_valid),    8'(tbl[i].cv));
            chk($sformatf("tbl%0d:col_sel", i),  8'(col_select),   8'(tbl[i].cs));
            chk($sformatf("tbl%0d:busy", i),     8'(busy),         8'(tbl[i].bsy));
            chk($sformatf("tbl%0d:msg_done", i), 8'(msg_done),     8'(tbl[i].md));
        end

        // Back-pressure: four in flight, collector stalled, then one ack frees lane 0.
        do_reset();
        cyc(1, 0, 0, '1, '0, 0, "a_idle");
        cyc(0, 0, 0, '1, '0, 0, "a_prog");
        chk("a_prog_all", 8'(enc_program), 8'hF);
        cyc(0, 0, 0, '1, '0, 0, "a_key");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, '1, '0, 0, "a_fill");
        cyc(0, 1, 0, '1, '1, 0, "a_full");
        chk("a_full_block", 8'(word_accept), 8'd0);
        cyc(0, 1, 0, '1, '1, 1, "a_ack");
        chk("a_ack_cap0", 8'(enc_capture), 8'h1);
        chk("a_ack_block", 8'(word_accept), 8'd0);
        cyc(0, 1, 1, '1, '1, 1, "a_next");
        chk("a_next_lane0", 8'(enc_dispatch), 8'h1);
        chk("a_next_cap1", 8'(enc_capture), 8'h2);
        drain("a_drain");

        // Out-of-order completion still collects lane 0 first.
        cyc(1, 0, 0, '1, '0, 0, "b_idle");
        cyc(0, 0, 0, '1, '0, 0, "b_prog");
        cyc(0, 0, 0, '1, '0, 0, "b_key");
        cyc(0, 1, 0, '1, '0, 0, "b_w0");
        cyc(0, 1, 0, '1, '0, 0, "b_w1");
        cyc(0, 1, 1, '1, '0, 0, "b_w2");
        cyc(0, 0, 0, '1, 4'b0100, 1, "b_d2");
        chk("b_d2_cv", 8'(col_valid), 8'd0);
        cyc(0, 0, 0, '1, 4'b0110, 1, "b_d1");
        chk("b_d1_cv", 8'(col_valid), 8'd0);
        cyc(0, 0, 0, '1, 4'b0111, 1, "b_c0");
        chk("b_c0_cap", 8'(enc_capture), 8'h1);
        cyc(0, 0, 0, '1, 4'b0111, 1, "b_c1");
        chk("b_c1_cap", 8'(enc_capture), 8'h2);
        cyc(0, 0, 0, '1, 4'b0111, 1, "b_c2");
        chk("b_c2_cap", 8'(enc_capture), 8'h4);
        drain("b_drain");

        // Reset mid-RUN with three results pending.
        cyc(1, 0, 0, '1, '0, 0, "c_idle");
        cyc(0, 0, 0, '1, '0, 0, "c_prog");
        cyc(0, 0, 0, '1, '0, 0, "c_key");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '1, '0, 0, "c_fill");
        @(posedge clk); #1;
        drive(0, 1, 0, '1, '1, 1);
        #1 reset = 1'b0;
        #1;
        chk("c_rst:accept",   8'(word_accept),  8'd0);
        chk("c_rst:dispatch", 8'(enc_dispatch), 8'd0);
        chk("c_rst:capture",  8'(enc_capture),  8'd0);
        chk("c_rst:col_valid",8'(col_valid),    8'd0);
        chk("c_rst:col_sel",  8'(col_select),   8'd0);
        chk("c_rst:busy",     8'(busy),         8'd0);
        chk("c_rst:program",  8'(enc_program),  8'd0);
        @(negedge clk);
        chk("c_rst_hold:capture", 8'(enc_capture), 8'd0);
        reset = 1'b1;
        model_reset();
        cyc(0, 1, 0, '1, '1, 1, "c_after");

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            prog       = ($urandom_range(0, 7) == 0);
            word_valid = ($urandom_range(0, 3) != 0);
            word_last  = ($urandom_range(0, 9) == 0);
            enc_ready  = ($urandom_range(0, 4) == 0) ? N'($urandom) : '1;
            enc_done   = N'($urandom);
            col_ack    = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
